// File: rtl/grid_interact_arbiter_if.sv
// Player-side request/response bundle for the interact arbiter.
interface grid_interact_arbiter_if #(
  parameter int unsigned OBJ_W = 4
) ();
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][3:0]       req_x;
  logic [1:0][2:0]       req_y;
  logic [1:0][1:0]       req_dir;
  logic [1:0][OBJ_W-1:0] req_held;
  logic [1:0]            resp_valid;
  logic [OBJ_W-1:0]      resp_held;
  logic [1:0]            resp_status;

  // Players drive requests and consume responses.
  modport master (
    output req_valid, req_x, req_y, req_dir, req_held,
    input  req_ready, resp_valid, resp_held, resp_status
  );

  // The arbiter accepts requests and produces responses.
  modport slave (
    input  req_valid, req_x, req_y, req_dir, req_held,
    output req_ready, resp_valid, resp_held, resp_status
  );
endinterface

// File: rtl/grid_interact_arbiter.sv
// Serialises both players' interact requests onto the single object-grid port:
// resolves the front cell, does a read-modify-write and returns the new held object.
module grid_interact_arbiter #(
  parameter int unsigned GRID_W = 13,
  parameter int unsigned GRID_H = 8,
  parameter int unsigned OBJ_W  = 4
) (
  input  logic                   clk_in,
  input  logic                   rstn_in,
  grid_interact_arbiter_if.slave ply,
  output logic [3:0]             rd_x,
  output logic [2:0]             rd_y,
  input  logic [OBJ_W-1:0]       rd_data,
  output logic                   wr_en,
  output logic [3:0]             wr_x,
  output logic [2:0]             wr_y,
  output logic [OBJ_W-1:0]       wr_data
);
  localparam int unsigned X_W = 4;
  localparam int unsigned Y_W = 3;
  localparam int unsigned C_W = 5;

  localparam logic signed [C_W-1:0] GRID_W_S = C_W'(GRID_W);
  localparam logic signed [C_W-1:0] GRID_H_S = C_W'(GRID_H);
  localparam logic signed [C_W-1:0] ONE_S    = C_W'(1);

  localparam logic [OBJ_W-1:0] G_EMPTY         = OBJ_W'(0);
  localparam logic [OBJ_W-1:0] G_ONION_WHOLE   = OBJ_W'(1);
  localparam logic [OBJ_W-1:0] G_ONION_CHOPPED = OBJ_W'(2);
  localparam logic [OBJ_W-1:0] G_BOWL_EMPTY    = OBJ_W'(3);
  localparam logic [OBJ_W-1:0] G_BOWL_FULL     = OBJ_W'(4);
  localparam logic [OBJ_W-1:0] G_POT_EMPTY     = OBJ_W'(5);
  localparam logic [OBJ_W-1:0] G_POT_RAW       = OBJ_W'(6);
  localparam logic [OBJ_W-1:0] G_POT_COOKED    = OBJ_W'(7);
  localparam logic [OBJ_W-1:0] G_POT_FIRE      = OBJ_W'(8);
  localparam logic [OBJ_W-1:0] G_FIRE          = OBJ_W'(9);
  localparam logic [OBJ_W-1:0] G_EXTINGUISHER  = OBJ_W'(10);

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [1:0] ST_NOP   = 2'd0;
  localparam logic [1:0] ST_PICK  = 2'd1;
  localparam logic [1:0] ST_PLACE = 2'd2;
  localparam logic [1:0] ST_OOB   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_RSP} state_t;

  state_t           state;
  logic             last_grant;
  logic             player;
  logic             oob;
  logic [OBJ_W-1:0] held;
  logic [1:0]       ready;
  logic [1:0]       resp_valid;
  logic [OBJ_W-1:0] resp_held;
  logic [1:0]       resp_status;

  logic [1:0]              grant_c;
  logic [1:0]              accept_c;
  logic                    acc_id_c;
  logic signed [C_W-1:0]   cand_x_c;
  logic signed [C_W-1:0]   cand_y_c;
  logic                    oob_c;
  logic [OBJ_W-1:0]        new_held_c;
  logic [OBJ_W-1:0]        new_cell_c;
  logic [1:0]              status_c;
  logic                    held_is_pot_c;
  logic                    cell_pickable_c;

  assign ply.req_ready   = ready;
  assign ply.resp_valid  = resp_valid;
  assign ply.resp_held   = resp_held;
  assign ply.resp_status = resp_status;

  assign accept_c = ply.req_valid & ready;
  assign acc_id_c = accept_c[1];

  // Round-robin grant: a lone requester wins, a tie goes to the player not granted last.
  always_comb begin
    grant_c = 2'b00;
    unique case (ply.req_valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  // Front cell of the accepting player at signed width so edges never wrap.
  always_comb begin
    cand_x_c = $signed({{(C_W-X_W){1'b0}}, ply.req_x[acc_id_c]});
    cand_y_c = $signed({{(C_W-Y_W){1'b0}}, ply.req_y[acc_id_c]});
    unique case (ply.req_dir[acc_id_c])
      DIR_LEFT:  cand_x_c = cand_x_c - ONE_S;
      DIR_RIGHT: cand_x_c = cand_x_c + ONE_S;
      DIR_UP:    cand_y_c = cand_y_c - ONE_S;
      DIR_DOWN:  cand_y_c = cand_y_c + ONE_S;
      default:   cand_x_c = cand_x_c;
    endcase
    oob_c = cand_x_c[C_W-1] || (cand_x_c >= GRID_W_S) ||
            cand_y_c[C_W-1] || (cand_y_c >= GRID_H_S);
  end

  // Interaction rules on (held, cell); first match wins, default leaves both untouched.
  always_comb begin
    new_held_c      = held;
    new_cell_c      = rd_data;
    status_c        = ST_NOP;
    held_is_pot_c   = (held == G_POT_EMPTY) || (held == G_POT_RAW) ||
                      (held == G_POT_COOKED) || (held == G_POT_FIRE);
    cell_pickable_c = (rd_data == G_ONION_WHOLE) || (rd_data == G_ONION_CHOPPED) ||
                      (rd_data == G_BOWL_EMPTY) || (rd_data == G_BOWL_FULL) ||
                      (rd_data == G_EXTINGUISHER);
    if (held == G_EMPTY && cell_pickable_c) begin
      new_held_c = rd_data;
      new_cell_c = G_EMPTY;
      status_c   = ST_PICK;
    end else if (held == G_ONION_CHOPPED && rd_data == G_POT_EMPTY) begin
      new_held_c = G_EMPTY;
      new_cell_c = G_POT_RAW;
      status_c   = ST_PLACE;
    end else if (held == G_BOWL_EMPTY && rd_data == G_POT_COOKED) begin
      new_held_c = G_BOWL_FULL;
      new_cell_c = G_POT_EMPTY;
      status_c   = ST_PLACE;
    end else if (held == G_EXTINGUISHER && rd_data == G_FIRE) begin
      new_held_c = G_EXTINGUISHER;
      new_cell_c = G_EMPTY;
      status_c   = ST_PLACE;
    end else if (held == G_EXTINGUISHER && rd_data == G_POT_FIRE) begin
      new_held_c = G_EXTINGUISHER;
      new_cell_c = G_POT_EMPTY;
      status_c   = ST_PLACE;
    end else if (held != G_EMPTY && rd_data == G_EMPTY &&
                 held != G_FIRE && !held_is_pot_c) begin
      new_held_c = G_EMPTY;
      new_cell_c = held;
      status_c   = ST_PLACE;
    end
  end

  // Request FSM: accept, read the front cell, evaluate, then pulse write and response.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      ready       <= 2'b00;
      player      <= 1'b0;
      oob         <= 1'b0;
      held        <= '0;
      rd_x        <= '0;
      rd_y        <= '0;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_data     <= '0;
      resp_valid  <= 2'b00;
      resp_held   <= '0;
      resp_status <= 2'b00;
    end else begin
      wr_en      <= 1'b0;
      resp_valid <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (|accept_c) begin
            ready      <= 2'b00;
            player     <= acc_id_c;
            last_grant <= acc_id_c;
            held       <= ply.req_held[acc_id_c];
            oob        <= oob_c;
            rd_x       <= oob_c ? '0 : X_W'(cand_x_c);
            rd_y       <= oob_c ? '0 : Y_W'(cand_y_c);
            state      <= S_RD;
          end else begin
            ready <= grant_c;
          end
        end
        S_RD: state <= S_EX;
        S_EX: begin
          state      <= S_RSP;
          resp_valid <= player ? 2'b10 : 2'b01;
          if (oob) begin
            resp_held   <= held;
            resp_status <= ST_OOB;
          end else begin
            resp_held   <= new_held_c;
            resp_status <= status_c;
            wr_en       <= (status_c == ST_PICK) || (status_c == ST_PLACE);
            wr_x        <= rd_x;
            wr_y        <= rd_y;
            wr_data     <= new_cell_c;
          end
        end
        S_RSP: begin
          state <= S_IDLE;
          ready <= grant_c;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_interact_arbiter.sv
// Randomised bench for grid_interact_arbiter with a transaction-level reference model.
module tb_grid_interact_arbiter;
  localparam int unsigned OBJ_W = 4;
  localparam int GW = 13;
  localparam int GH = 8;
  localparam int E = 0, OW = 1, OC = 2, BE = 3, BF = 4, PE = 5, PR = 6, PC = 7, PF = 8, FI = 9, EXT = 10;

  logic clk_in = 1'b0;
  logic rstn_in = 1'b0;
  logic [3:0]       rd_x;
  logic [2:0]       rd_y;
  logic [OBJ_W-1:0] rd_data;
  logic             wr_en;
  logic [3:0]       wr_x;
  logic [2:0]       wr_y;
  logic [OBJ_W-1:0] wr_data;

  grid_interact_arbiter_if #(.OBJ_W(OBJ_W)) ply ();

  grid_interact_arbiter #(.GRID_W(13), .GRID_H(8), .OBJ_W(OBJ_W)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .ply(ply),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data)
  );

  always #5 clk_in = ~clk_in;

  // Grid RAM: synchronous read, bench pokes take priority over DUT writes.
  logic [OBJ_W-1:0] ram [0:7][0:15];
  logic poke_en = 1'b0;
  int   poke_x, poke_y, poke_v;
  always @(posedge clk_in) begin
    rd_data <= ram[rd_y][rd_x];
    if (poke_en) ram[poke_y][poke_x] <= OBJ_W'(poke_v);
    else if (wr_en) ram[wr_y][wr_x] <= wr_data;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_hold = 0;
  int free_at = 0, dec_at = -1, dec_win = 0, last_win = 1;
  bit hs [2];
  bit pend [2];
  bit stg [2];
  int stg_x [2], stg_y [2], stg_d [2], stg_h [2];
  bit rand_en = 1'b0;
  bit exp_act = 1'b0;
  int acc_at, e_pl, e_held, e_st, e_wr, e_wx, e_wy, e_wd, e_rdx, e_rdy;
  int ref_grid [0:7][0:15];
  int acc_cyc [2];
  int obs_held, obs_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void rules(input int h, input int c, output int nh, output int nc, output int st);
    nh = h; nc = c; st = 0;
    if (h == E && (c == OW || c == OC || c == BE || c == BF || c == EXT)) begin nh = c; nc = E; st = 1; end
    else if (h == OC && c == PE) begin nh = E; nc = PR; st = 2; end
    else if (h == BE && c == PC) begin nh = BF; nc = PE; st = 2; end
    else if (h == EXT && c == FI) begin nh = EXT; nc = E; st = 2; end
    else if (h == EXT && c == PF) begin nh = EXT; nc = PE; st = 2; end
    else if (h != E && c == E && h != FI && !(h >= PE && h <= PF)) begin nh = E; nc = h; st = 2; end
  endfunction

  task automatic drive_req(input int p, input int x, input int y, input int d, input int h);
    pend[p] = 1'b1;
    ply.req_valid[p] = 1'b1;
    ply.req_x[p]     = 4'(x);
    ply.req_y[p]     = 3'(y);
    ply.req_dir[p]   = 2'(d);
    ply.req_held[p]  = OBJ_W'(h);
  endtask

  task automatic new_req(input int p, input int x, input int y, input int d, input int h);
    stg[p] = 1'b1; stg_x[p] = x; stg_y[p] = y; stg_d[p] = d; stg_h[p] = h;
  endtask

  // Model of one accepted transaction: target, bounds and rule outcome.
  task automatic model_accept(input int p);
    int x, y, d, h, tx, ty, nh, nc, st;
    x = int'(ply.req_x[p]); y = int'(ply.req_y[p]);
    d = int'(ply.req_dir[p]); h = int'(ply.req_held[p]);
    tx = x; ty = y;
    case (d)
      0: tx = x - 1;
      1: tx = x + 1;
      2: ty = y - 1;
      default: ty = y + 1;
    endcase
    exp_act = 1'b1; acc_at = cyc; e_pl = p; last_win = p; free_at = cyc + 3; acc_cyc[p] = cyc;
    if (tx < 0 || tx >= GW || ty < 0 || ty >= GH) begin
      e_rdx = 0; e_rdy = 0; e_wr = 0; e_held = h; e_st = 3;
    end else begin
      rules(h, ref_grid[ty][tx], nh, nc, st);
      e_rdx = tx; e_rdy = ty; e_held = nh; e_st = st;
      e_wr = (st != 0) ? 1 : 0; e_wx = tx; e_wy = ty; e_wd = nc;
    end
  endtask

  // One cycle: drive at the falling edge, check registered outputs, advance the model.
  task automatic step();
    int exp_rv;
    @(negedge clk_in);
    cyc++;
    if (rst_hold > 0) begin
      rstn_in = 1'b0; rst_hold--;
    end else if (!rstn_in) begin
      rstn_in = 1'b1; free_at = cyc;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin pend[i] = 1'b0; ply.req_valid[i] = 1'b0; hs[i] = 1'b0; end
      if (!pend[i] && stg[i]) begin
        stg[i] = 1'b0; drive_req(i, stg_x[i], stg_y[i], stg_d[i], stg_h[i]);
      end else if (!pend[i] && rand_en && $urandom_range(0, 3) == 0) begin
        drive_req(i, $urandom_range(0, GW - 1), $urandom_range(0, GH - 1),
                  $urandom_range(0, 3), $urandom_range(0, 10));
      end
    end
    if (!rstn_in) begin
      exp_act = 1'b0; dec_at = -1; last_win = 1;
      check("reset_outputs", {ply.req_ready, ply.resp_valid, wr_en, rd_x, rd_y, wr_x, wr_y,
                              wr_data, ply.resp_held, ply.resp_status}, 0);
    end else begin
      exp_rv = (exp_act && cyc == acc_at + 3) ? (1 << e_pl) : 0;
      check("resp_valid", ply.resp_valid, exp_rv);
      check("wr_en", wr_en, (exp_act && cyc == acc_at + 3) ? e_wr : 0);
      if (exp_act && cyc == acc_at + 1) begin
        check("rd_x", rd_x, e_rdx);
        check("rd_y", rd_y, e_rdy);
      end
      if (exp_act && cyc == acc_at + 3) begin
        check("resp_held", ply.resp_held, e_held);
        check("resp_status", ply.resp_status, e_st);
        if (e_wr != 0) begin
          check("wr_x", wr_x, e_wx);
          check("wr_y", wr_y, e_wy);
          check("wr_data", wr_data, e_wd);
          ref_grid[e_wy][e_wx] = e_wd;
        end
        obs_held = int'(ply.resp_held);
        obs_st   = int'(ply.resp_status);
        exp_act  = 1'b0;
      end
      check("req_ready", ply.req_ready, (dec_at >= 0 && cyc == dec_at + 1) ? (1 << dec_win) : 0);
      if (dec_at >= 0 && cyc == dec_at + 1) begin
        model_accept(dec_win);
        dec_at = -1;
      end
      if (dec_at < 0 && cyc >= free_at && ply.req_valid != 2'b00) begin
        dec_at  = cyc;
        dec_win = (ply.req_valid == 2'b11) ? (last_win == 1 ? 0 : 1) : (ply.req_valid[1] ? 1 : 0);
      end
      for (int i = 0; i < 2; i++) hs[i] = ply.req_valid[i] && ply.req_ready[i];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend[0] || pend[1] || stg[0] || stg[1] || exp_act || dec_at >= 0) && n < 60) begin
      step(); n++;
    end
    check("idle_timeout", n < 60, 1);
    step(); step();
  endtask

  task automatic set_cell(input int x, input int y, input int v);
    poke_x = x; poke_y = y; poke_v = v; poke_en = 1'b1;
    @(posedge clk_in); #1;
    poke_en = 1'b0;
    ref_grid[y][x] = v;
  endtask

  task automatic do_reset();
    rst_hold = 2;
    repeat (3) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ply.req_valid = '0; ply.req_x = '0; ply.req_y = '0; ply.req_dir = '0; ply.req_held = '0;
    hs[0] = 0; hs[1] = 0; pend[0] = 0; pend[1] = 0; stg[0] = 0; stg[1] = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) set_cell(x, y, $urandom_range(0, 10));
    do_reset();

    // Pick up a whole onion to the left.
    set_cell(0, 2, OW);
    new_req(0, 1, 2, 0, E);
    wait_idle();
    check("t1_held", obs_held, 1);
    check("t1_status", obs_st, 1);
    check("t1_cell", ram[2][0], 0);

    // Chopped onion into an empty pot above.
    set_cell(8, 0, PE);
    new_req(0, 8, 1, 2, OC);
    wait_idle();
    check("t2_held", obs_held, 0);
    check("t2_status", obs_st, 2);
    check("t2_cell", ram[0][8], PR);

    // Right edge is out of bounds.
    new_req(1, 12, 6, 1, BE);
    wait_idle();
    check("t3_held", obs_held, 3);
    check("t3_status", obs_st, 3);

    // Bottom edge and x=0 left edge are out of bounds.
    new_req(0, 4, 7, 3, OW);
    wait_idle();
    check("t3_down_status", obs_st, 3);
    new_req(1, 0, 3, 0, E);
    wait_idle();
    check("t3_left_status", obs_st, 3);

    // Simultaneous requests after reset: P0 first, P1 four cycles later, then P0 again.
    do_reset();
    new_req(0, 5, 5, 3, E);
    new_req(1, 9, 2, 2, E);
    wait_idle();
    check("t4_gap", acc_cyc[1] - acc_cyc[0], 4);
    new_req(0, 2, 2, 1, E);
    new_req(1, 10, 4, 0, E);
    wait_idle();
    check("t4_tie_p0_first", acc_cyc[1] - acc_cyc[0], 4);

    // Empty hand against a burning pot does nothing.
    set_cell(3, 4, PF);
    new_req(0, 4, 4, 0, E);
    wait_idle();
    check("t5_held", obs_held, 0);
    check("t5_status", obs_st, 0);
    check("t5_cell", ram[4][3], PF);

    // Reset during EX suppresses the write; a fresh request then completes.
    set_cell(7, 3, OW);
    new_req(0, 6, 3, 1, E);
    for (int n = 0; n < 20 && !(exp_act && cyc == acc_at + 1); n++) step();
    check("t6_reach_rd", exp_act, 1);
    rst_hold = 2;
    repeat (4) step();
    check("t6_cell_kept", ram[3][7], OW);
    obs_held = -1; obs_st = -1;
    new_req(0, 6, 3, 1, E);
    wait_idle();
    check("t6_held", obs_held, OW);
    check("t6_status", obs_st, 1);

    // Random traffic from both players against the model.
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
